// File: rtl/scan_shift_ctrl.sv
// -----------------------------------------------------------------------------
// scan_shift_ctrl
//
// Purpose:
//   Drives a test session through a DUT scan chain. Each pattern is shifted in
//   over CHAIN_LEN LOAD cycles and then captured for one cycle. The response of
//   pattern k is shifted out while pattern k+1 is loaded. A final FLUSH unloads
//   the last response. Every unloaded bit is compared against exp_in, and
//   mismatches are counted with a saturating counter.
//
// Parameters:
//   CHAIN_LEN  number of scan flops in the DUT chain
//   CNT_W      shift counter width, 2**CNT_W > CHAIN_LEN
//
// Ports:
//   CK              clock, rising edge
//   RST             synchronous active-high reset; all outputs read 0 while high
//   start           session start pulse, honoured only in IDLE
//   num_pat[15:0]   pattern count, sampled on the accepted start
//   pat_in          stimulus bit, valid in shift_req cycles
//   exp_in          expected unload bit, valid in shift_req cycles
//   scan_out        DUT chain serial output
//   shift_req       high in every shift cycle (LOAD, FLUSH)
//   scan_en         DUT scan enable
//   scan_in         DUT chain serial input
//   busy            high in every state other than IDLE
//   done            one-cycle end-of-session pulse
//   fail            sticky mismatch flag for the current session
//   err_cnt[15:0]   saturating mismatch count
//   first_fail_pat  pattern index of the first mismatch
//   first_fail_bit  shift index of the first mismatch within its unload
//
// Configuration:
//   SCAN_SHIFT_CTRL_FIRST_FAIL_EN  when defined, captures the location of the
//   first mismatch. When undefined, first_fail_* are tied to 0.
// -----------------------------------------------------------------------------
module scan_shift_ctrl #(
  parameter int CHAIN_LEN = 211,
  parameter int CNT_W     = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [15:0]      num_pat,
  input  logic             pat_in,
  input  logic             exp_in,
  input  logic             scan_out,
  output logic             shift_req,
  output logic             scan_en,
  output logic             scan_in,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_fail_pat,
  output logic [CNT_W-1:0] first_fail_bit
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_shift_cnt;
  logic [CNT_W-1:0] w_shift_cnt_nxt;
  logic [15:0]      r_pat_cnt;
  logic [15:0]      w_pat_cnt_nxt;
  logic [15:0]      w_pat_inc;
  logic [15:0]      r_num_pat;
  logic [15:0]      r_err_cnt;
  logic             r_fail;

  logic w_start_ok;
  logic w_shift_last;
  logic w_cmp;
  logic w_mis;
  logic w_scan_en;
  logic w_shift_req;
  logic w_scan_in;
  logic w_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_start_ok   = start && (r_state == ST_IDLE);
  assign w_shift_last = (r_shift_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_pat_inc    = r_pat_cnt + 16'd1;

  // The pattern counter is incremented in CAPTURE, so a nonzero count during
  // LOAD means the chain holds a captured response worth comparing.
  assign w_cmp = ((r_state == ST_LOAD) && (r_pat_cnt != 16'd0)) ||
                 (r_state == ST_FLUSH);
  assign w_mis = w_cmp && (scan_out != exp_in);

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_cnt_nxt = r_shift_cnt;
    w_pat_cnt_nxt   = r_pat_cnt;
    w_scan_en       = 1'b0;
    w_shift_req     = 1'b0;
    w_scan_in       = 1'b0;
    w_done          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pat_cnt_nxt   = 16'd0;
          w_shift_cnt_nxt = '0;
          w_state_nxt     = (num_pat == 16'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_scan_en   = 1'b1;
        w_shift_req = 1'b1;
        w_scan_in   = pat_in;
        if (w_shift_last) begin
          w_shift_cnt_nxt = '0;
          w_state_nxt     = ST_CAPTURE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_pat_cnt_nxt = w_pat_inc;
        w_state_nxt   = (w_pat_inc < r_num_pat) ? ST_LOAD : ST_FLUSH;
      end
      ST_FLUSH: begin
        w_scan_en   = 1'b1;
        w_shift_req = 1'b1;
        if (w_shift_last) begin
          w_shift_cnt_nxt = '0;
          w_state_nxt     = ST_DONE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= 16'd0;
      r_num_pat   <= 16'd0;
      r_err_cnt   <= 16'd0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_pat_cnt   <= w_pat_cnt_nxt;
      if (w_start_ok) begin
        r_num_pat <= num_pat;
        r_err_cnt <= 16'd0;
        r_fail    <= 1'b0;
      end else if (w_mis) begin
        r_err_cnt <= sat_inc16(r_err_cnt);
        r_fail    <= 1'b1;
      end
    end
  end

`ifdef SCAN_SHIFT_CTRL_FIRST_FAIL_EN
  logic [15:0]      r_ff_pat;
  logic [CNT_W-1:0] r_ff_bit;

  // The unload in progress belongs to the pattern before the current count.
  // In FLUSH the count equals num_pat, so this also names the last pattern.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_ff_pat <= 16'd0;
      r_ff_bit <= '0;
    end else if (w_start_ok) begin
      r_ff_pat <= 16'd0;
      r_ff_bit <= '0;
    end else if (w_mis && !r_fail) begin
      r_ff_pat <= r_pat_cnt - 16'd1;
      r_ff_bit <= r_shift_cnt;
    end
  end

  assign first_fail_pat = RST ? 16'd0 : r_ff_pat;
  assign first_fail_bit = RST ? '0    : r_ff_bit;
`else
  assign first_fail_pat = 16'd0;
  assign first_fail_bit = '0;
`endif

  // Outputs are forced low combinationally while reset is held.
  assign scan_en   = !RST && w_scan_en;
  assign shift_req = !RST && w_shift_req;
  assign scan_in   = !RST && w_scan_in;
  assign busy      = !RST && (r_state != ST_IDLE);
  assign done      = !RST && w_done;
  assign fail      = !RST && r_fail;
  assign err_cnt   = RST ? 16'd0 : r_err_cnt;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
module tb_scan_shift_ctrl;

  localparam int CL_A = 4;
  localparam int CW_A = 3;
  localparam int CL_B = 211;
  localparam int CW_B = 8;

`ifdef SCAN_SHIFT_CTRL_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic CK = 1'b0;
  always #5 CK = ~CK;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Instance A: short chain for directed schedule checks
  logic            rst_a, start_a, pat_in_a, exp_in_a, scan_out_a, flip_a;
  logic [15:0]     num_pat_a;
  logic            shift_req_a, scan_en_a, scan_in_a, busy_a, done_a, fail_a;
  logic [15:0]     err_cnt_a, ffp_a;
  logic [CW_A-1:0] ffb_a;
  logic [CL_A-1:0] chain_a = '0;

  // Instance B: default-length chain for saturation
  logic            rst_b, start_b, pat_in_b, exp_in_b, scan_out_b, flip_b;
  logic [15:0]     num_pat_b;
  logic            shift_req_b, scan_en_b, scan_in_b, busy_b, done_b, fail_b;
  logic [15:0]     err_cnt_b, ffp_b;
  logic [CW_B-1:0] ffb_b;
  logic [CL_B-1:0] chain_b = '0;

  // Simple model of the DUT scan chains
  always @(posedge CK) if (scan_en_a) chain_a <= {chain_a[CL_A-2:0], scan_in_a};
  always @(posedge CK) if (scan_en_b) chain_b <= {chain_b[CL_B-2:0], scan_in_b};
  assign scan_out_a = chain_a[CL_A-1];
  assign scan_out_b = chain_b[CL_B-1];
  assign exp_in_a   = scan_out_a ^ flip_a;
  assign exp_in_b   = scan_out_b ^ flip_b;

  scan_shift_ctrl #(.CHAIN_LEN(CL_A), .CNT_W(CW_A)) u_dut_a (
    .CK(CK), .RST(rst_a), .start(start_a), .num_pat(num_pat_a),
    .pat_in(pat_in_a), .exp_in(exp_in_a), .scan_out(scan_out_a),
    .shift_req(shift_req_a), .scan_en(scan_en_a), .scan_in(scan_in_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .err_cnt(err_cnt_a),
    .first_fail_pat(ffp_a), .first_fail_bit(ffb_a)
  );

  scan_shift_ctrl #(.CHAIN_LEN(CL_B), .CNT_W(CW_B)) u_dut_b (
    .CK(CK), .RST(rst_b), .start(start_b), .num_pat(num_pat_b),
    .pat_in(pat_in_b), .exp_in(exp_in_b), .scan_out(scan_out_b),
    .shift_req(shift_req_b), .scan_en(scan_en_b), .scan_in(scan_in_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .err_cnt(err_cnt_b),
    .first_fail_pat(ffp_b), .first_fail_bit(ffb_b)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  // Expected state in cycle c after the accepted start: 0 IDLE, 1 LOAD,
  // 2 CAPTURE, 3 FLUSH, 4 DONE.
  function automatic int sched(input int c, input int n, input int cl);
    int per;
    per = cl + 1;
    if (n == 0) return (c == 1) ? 4 : 0;
    if (c <= per * n) return (((c - 1) % per) < cl) ? 1 : 2;
    if (c <= per * n + cl) return 3;
    if (c == per * n + cl + 1) return 4;
    return 0;
  endfunction

  // Runs one session on instance A; exp_in is inverted in cycles lo..hi.
  task automatic run_a(input int n, input int lo, input int hi, input int e_err,
                       input bit e_fail, input int e_fpat, input int e_fbit,
                       input string name);
    int   done_exp;
    int   st;
    logic [4:0] want;
    done_exp  = (n == 0) ? 1 : (CL_A + 1) * n + CL_A + 1;
    num_pat_a = 16'(n);
    flip_a    = 1'b0;
    start_a   = 1'b1;
    tick;
    start_a   = 1'b0;
    for (int c = 1; c <= done_exp + 1; c++) begin
      pat_in_a = 1'($urandom_range(0, 1));
      flip_a   = (c >= lo) && (c <= hi);
      // A start while busy, with a different count, must be ignored
      start_a  = (n > 0) && (c == 2);
      if (c == 2) num_pat_a = 16'(n + 1);
      #1;
      st = sched(c, n, CL_A);
      want = {(st == 1 || st == 3), (st == 1 || st == 3),
              (st == 1) ? pat_in_a : 1'b0, (st != 0), (st == 4)};
      vec_cnt++;
      if ({scan_en_a, shift_req_a, scan_in_a, busy_a, done_a} !== want) begin
        miss_cnt++;
        $display("FAIL %s cycle %0d en/req/in/busy/done: got %b want %b", name, c,
                 {scan_en_a, shift_req_a, scan_in_a, busy_a, done_a}, want);
      end
      if (c == 1) begin
        vec_cnt++;
        if (err_cnt_a !== 16'd0 || fail_a !== 1'b0) begin
          miss_cnt++;
          $display("FAIL %s clear_on_start: got err=%0d fail=%b want 0/0", name,
                   err_cnt_a, fail_a);
        end
      end
      tick;
    end
    start_a = 1'b0;
    flip_a  = 1'b0;
    vec_cnt++;
    if (err_cnt_a !== 16'(e_err) || fail_a !== e_fail) begin
      miss_cnt++;
      $display("FAIL %s result: got err=%0d fail=%b want err=%0d fail=%b", name,
               err_cnt_a, fail_a, e_err, e_fail);
    end
    vec_cnt++;
    if (ffp_a !== 16'(e_fpat) || ffb_a !== CW_A'(e_fbit)) begin
      miss_cnt++;
      $display("FAIL %s first_fail: got pat=%0d bit=%0d want pat=%0d bit=%0d", name,
               ffp_a, ffb_a, e_fpat, e_fbit);
    end
  endtask

  task automatic check_zero_a(input string name);
    vec_cnt++;
    if ({scan_en_a, shift_req_a, scan_in_a, busy_a, done_a, fail_a} !== 6'b0 ||
        err_cnt_a !== 16'd0 || ffp_a !== 16'd0 || ffb_a !== '0) begin
      miss_cnt++;
      $display("FAIL %s outputs: got en/req/in/busy/done/fail=%b err=%0d ffp=%0d ffb=%0d want all 0",
               name, {scan_en_a, shift_req_a, scan_in_a, busy_a, done_a, fail_a},
               err_cnt_a, ffp_a, ffb_a);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; start_a = 1'b1; num_pat_a = 16'd5; pat_in_a = 1'b1; flip_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; num_pat_b = 16'd0; pat_in_b = 1'b0; flip_b = 1'b0;
    tick;
    tick;
    check_zero_a("reset_held");
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0;
    #1;
    check_zero_a("reset_released");
    tick;
    check_zero_a("reset_idle");
  endtask

  task automatic test_single_pattern;
    run_a(1, 100, 0, 0, 1'b0, 0, 0, "single_pat");
  endtask

  task automatic test_first_fail;
    run_a(3, 13, 13, 1, 1'b1, FF_EN ? 1 : 0, FF_EN ? 2 : 0, "first_fail");
  endtask

  task automatic test_hold_and_first_load;
    for (int i = 0; i < 3; i++) tick;
    vec_cnt++;
    if (err_cnt_a !== 16'd1 || fail_a !== 1'b1 || busy_a !== 1'b0) begin
      miss_cnt++;
      $display("FAIL hold_idle: got err=%0d fail=%b busy=%b want 1/1/0",
               err_cnt_a, fail_a, busy_a);
    end
    // Mismatches during the first LOAD and the CAPTURE are not compared
    run_a(2, 1, 5, 0, 1'b0, 0, 0, "first_load_ignored");
  endtask

  task automatic test_multi_err;
    run_a(3, 12, 19, 7, 1'b1, FF_EN ? 1 : 0, FF_EN ? 1 : 0, "multi_err");
  endtask

  task automatic test_flush;
    run_a(2, 11, 14, 4, 1'b1, FF_EN ? 1 : 0, 0, "flush_cmp");
  endtask

  task automatic test_zero_pat;
    run_a(0, 1, 2, 0, 1'b0, 0, 0, "zero_pat");
  endtask

  task automatic test_reset_midsession;
    num_pat_a = 16'd2;
    start_a   = 1'b1;
    tick;
    start_a   = 1'b0;
    tick;
    tick;
    // Third LOAD cycle: reset wins over a simultaneous start
    rst_a   = 1'b1;
    start_a = 1'b1;
    #1;
    check_zero_a("mid_reset_held");
    tick;
    rst_a   = 1'b0;
    start_a = 1'b0;
    #1;
    check_zero_a("mid_reset_after");
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
        miss_cnt++;
        $display("FAIL mid_reset_idle cycle %0d: got busy=%b done=%b want 0/0",
                 i, busy_a, done_a);
      end
      tick;
    end
    run_a(1, 100, 0, 0, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_saturate;
    int done_exp;
    int done_seen;
    int done_cyc;
    done_exp  = (CL_B + 1) * 320 + CL_B + 1;
    done_seen = 0;
    done_cyc  = 0;
    // 320 patterns give 67520 compared bits, past the 16-bit limit
    num_pat_b = 16'd320;
    flip_b    = 1'b1;
    start_b   = 1'b1;
    tick;
    start_b   = 1'b0;
    for (int c = 1; c <= done_exp + 1; c++) begin
      pat_in_b = 1'($urandom_range(0, 1));
      start_b  = ((c % 5000) == 0);
      if (c == 100) num_pat_b = 16'd1;
      #1;
      if (done_b === 1'b1) begin
        done_seen++;
        done_cyc = c;
      end
      if (c == done_exp - 50) begin
        vec_cnt++;
        if (err_cnt_b !== 16'hFFFF) begin
          miss_cnt++;
          $display("FAIL sat_reached: got err=%0d want 65535", err_cnt_b);
        end
      end
      tick;
    end
    start_b = 1'b0;
    flip_b  = 1'b0;
    vec_cnt++;
    if (done_seen != 1 || done_cyc != done_exp) begin
      miss_cnt++;
      $display("FAIL sat_done: got %0d pulses at cycle %0d want 1 at %0d",
               done_seen, done_cyc, done_exp);
    end
    vec_cnt++;
    if (err_cnt_b !== 16'hFFFF || fail_b !== 1'b1 || busy_b !== 1'b0) begin
      miss_cnt++;
      $display("FAIL sat_final: got err=%0d fail=%b busy=%b want 65535/1/0",
               err_cnt_b, fail_b, busy_b);
    end
    vec_cnt++;
    if (ffp_b !== 16'd0 || ffb_b !== '0) begin
      miss_cnt++;
      $display("FAIL sat_first_fail: got pat=%0d bit=%0d want 0/0", ffp_b, ffb_b);
    end
  endtask

  initial begin
    test_reset;
    test_single_pattern;
    test_first_fail;
    test_hold_and_first_load;
    test_multi_err;
    test_flush;
    test_zero_pat;
    test_reset_midsession;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
